dmem_boot: RTL and testbench
============================

Name: dmem_boot

Overview:
- Memory/bus stage directly downstream of the dCPU core: it owns the 256-byte unified program/data RAM that the CPU's addr/R/W/data_out bus drives, and returns read data on mem_in.
- A boot-loader FSM fills the RAM from a byte-stream valid/ready port while holding the CPU in reset, then releases it.
- One address is a memory-mapped I/O port: writes latch an output register, reads return an external input.

Parameters:
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, data width.
- IO_ADDR, 8'hFF, address decoded as the I/O port instead of RAM.
- LOAD_ON_RESET, 1: 1 = reset enters LOAD; 0 = reset enters RUN and the RAM keeps its existing contents.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- cpu_addr  in  ADDR_W  CPU address bus.
- cpu_R  in  1  read strobe, active low.
- cpu_W  in  1  write strobe, active low.
- cpu_wdata  in  DATA_W  CPU write data (data_out).
- cpu_rdata  out  DATA_W  read data to CPU (mem_in).
- cpu_rst  out  1  reset to CPU; high while loading.
- load_valid  in  1  loader byte valid.
- load_ready  out  1  loader byte accepted when valid&&ready at posedge.
- load_data  in  DATA_W  loader byte.
- load_last  in  1  marks final byte of the image.
- reload  in  1  single-cycle request to re-enter LOAD from RUN.
- io_in  in  DATA_W  external input, read at IO_ADDR.
- io_out  out  DATA_W  output register, written at IO_ADDR.
- load_count  out  ADDR_W+1  bytes accepted in the current/last load.
- load_ovf  out  1  sticky: image exceeded RAM depth.

Behaviour:
- States: LOAD and RUN. On any clock edge with rst=1: state <= (LOAD_ON_RESET ? LOAD : RUN), ptr <= 0, load_count <= 0, io_out <= 0, load_ovf <= 0. RAM contents are not cleared.
- cpu_rst = rst | (state==LOAD), combinational.
- load_ready = (state==LOAD) & ~rst, combinational.
- LOAD, accepted byte (valid&&ready):
  - mem[ptr] <= load_data; ptr <= ptr+1 (wraps at 2**ADDR_W); load_count <= load_count+1.
  - If load_last is set: state <= RUN. cpu_rst drops in the cycle after the last byte is accepted.
  - If ptr == 2**ADDR_W-1 and load_last is clear: the byte is still written, load_ovf <= 1, state <= RUN. Later valids are not accepted.
- LOAD, no accept: all state holds. In LOAD, reload is ignored, CPU strobes are ignored, and cpu_rdata = 0.
- RUN, reads: combinational, zero latency, so data is available in the same cycle R is low.
  - cpu_rdata = (cpu_R==0) ? (cpu_addr==IO_ADDR ? io_in : mem[cpu_addr]) : 0.
- RUN, writes: on posedge with cpu_W==0:
  - If cpu_addr==IO_ADDR: io_out <= cpu_wdata, and RAM is not written.
  - Otherwise: mem[cpu_addr] <= cpu_wdata.
- RUN, reads and writes together: if R and W are both low, the read returns the old value; the write lands at the edge.
- RUN, reload=1: state <= LOAD, ptr <= 0, load_count <= 0, load_ovf <= 0. io_out holds its value. cpu_rst rises in the next cycle, and a CPU write in the same cycle as reload is still performed.
- rst mid-load: the load is abandoned and ptr returns to 0. Bytes already written stay in RAM.
- load_count saturates: it cannot exceed 2**ADDR_W by construction.

Test Plan:
- Reset, then stream bytes C1,D0,C6,10 with load_last on the 4th byte, valid held high → accepted on 4 consecutive edges, mem[0..3] = C1,D0,C6,10, load_count=4, cpu_rst falls in the cycle after the 4th accept.
- Before loading, toggle load_valid in a 1-0-1 pattern → only valid cycles are accepted and ptr does not skip. In LOAD, drive cpu_R=0 at addr 0 → cpu_rdata=00.
- In RUN, drive cpu_R=0 with addr=2 → cpu_rdata=C6 in the same cycle. Drive cpu_R=1 → cpu_rdata=00.
- In RUN, write 5A to addr 80, then read addr 80 → 5A. Write 3C to addr FF → io_out=3C and mem[FF] unchanged. With io_in=A7, read addr FF → A7.
- Stream 256 bytes with no load_last → load_ovf=1, load_count=256, RUN entered after byte 256, and a 257th valid gets load_ready=0.
- In RUN, pulse reload, then assert rst during the 2nd byte of the new load → cpu_rst high throughout, load_count=0 after reset, and mem[0] holds the byte loaded before reset.

Source files
------------

// File: rtl/dmem_boot_if.sv
// rtl/dmem_boot_if.sv - CPU bus, boot-loader stream, I/O port and load status bundle for dmem_boot
//   master : CPU/loader side; drives cpu_addr/cpu_R/cpu_W/cpu_wdata, load_valid/load_data/load_last, reload, io_in
//   slave  : memory side; drives cpu_rdata, cpu_rst, load_ready, io_out, load_count, load_ovf
interface dmem_boot_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_R;       // active low
    logic              cpu_W;       // active low
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rst;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              reload;
    logic [DATA_W-1:0] io_in;
    logic [DATA_W-1:0] io_out;
    logic [ADDR_W:0]   load_count;
    logic              load_ovf;

    modport master (
        output cpu_addr, cpu_R, cpu_W, cpu_wdata,
        output load_valid, load_data, load_last, reload, io_in,
        input  cpu_rdata, cpu_rst, load_ready, io_out, load_count, load_ovf
    );

    modport slave (
        input  cpu_addr, cpu_R, cpu_W, cpu_wdata,
        input  load_valid, load_data, load_last, reload, io_in,
        output cpu_rdata, cpu_rst, load_ready, io_out, load_count, load_ovf
    );
endinterface

// File: rtl/dmem_boot.sv
// rtl/dmem_boot.sv - unified program/data RAM with boot-loader FSM and one memory-mapped I/O port
//   clk  : single clock, posedge
//   rst  : synchronous active-high reset
//   bus  : dmem_boot_if.slave - CPU bus (addr/R/W/wdata -> rdata), CPU reset, loader byte stream,
//          reload request, io_in/io_out port, load_count and sticky load_ovf status
module dmem_boot #(
    parameter int              ADDR_W        = 8,
    parameter int              DATA_W        = 8,
    parameter logic [ADDR_W-1:0] IO_ADDR     = 8'hFF,
    parameter bit              LOAD_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_boot_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [DATA_W-1:0] io_out_q;
    logic              ovf_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              in_load;
    logic              accept;
    logic              io_hit;
    logic              cpu_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_load = (state_q == S_LOAD);
    assign accept  = bus.load_valid & bus.load_ready;
    assign io_hit  = (bus.cpu_addr == IO_ADDR);
    // CPU strobes only count in RUN and never while reset is asserted.
    assign cpu_wr  = ~rst & ~in_load & ~bus.cpu_W;

    assign bus.cpu_rst    = rst | in_load;
    assign bus.load_ready = in_load & ~rst;
    assign bus.load_count = count_q;
    assign bus.load_ovf   = ovf_q;
    assign bus.io_out     = io_out_q;

    // Zero-latency read; a simultaneous write lands at the edge, so the old value is returned.
    always_comb begin
        bus.cpu_rdata = '0;
        if (!in_load && !bus.cpu_R) begin
            bus.cpu_rdata = io_hit ? bus.io_in : mem_q[bus.cpu_addr];
        end
    end

    // The RAM write port is shared: loader owns it in LOAD, the CPU in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.cpu_addr;
        mem_wdata = bus.cpu_wdata;
        if (in_load) begin
            mem_we    = accept;
            mem_waddr = ptr_q;
            mem_wdata = bus.load_data;
        end else begin
            mem_we    = cpu_wr & ~io_hit;
        end
    end

    // RAM contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD_ON_RESET ? S_LOAD : S_RUN;
            ptr_q    <= '0;
            count_q  <= '0;
            io_out_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        ptr_q   <= ptr_q + PTR_ONE;
                        count_q <= count_q + CNT_ONE;
                        if (bus.load_last) begin
                            state_q <= S_RUN;
                        end else if (ptr_q == {ADDR_W{1'b1}}) begin
                            // Image filled the whole RAM without a last marker: stop and flag it.
                            ovf_q   <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                default: begin
                    if (cpu_wr && io_hit) begin
                        io_out_q <= bus.cpu_wdata;
                    end
                    if (bus.reload) begin
                        state_q <= S_LOAD;
                        ptr_q   <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_boot.sv
// tb/tb_dmem_boot.sv - directed self-checking bench for dmem_boot
module tb_dmem_boot;
    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    dmem_boot_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dmem_boot #(
        .ADDR_W(8), .DATA_W(8), .IO_ADDR(8'hFF), .LOAD_ON_RESET(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] first_img [4];
    logic [7:0] b;

    initial begin
        first_img[0] = 8'hC1; first_img[1] = 8'hD0;
        first_img[2] = 8'hC6; first_img[3] = 8'h10;

        rst = 1'b1;
        bus.cpu_addr = '0; bus.cpu_R = 1'b1; bus.cpu_W = 1'b1; bus.cpu_wdata = '0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        bus.reload = 1'b0; bus.io_in = '0;
        tick();
        tick();

        // reset state
        chk("rst_cpu_rst", bus.cpu_rst, 1);
        chk("rst_ready", bus.load_ready, 0);
        chk("rst_count", bus.load_count, 0);
        chk("rst_ovf", bus.load_ovf, 0);
        chk("rst_io_out", bus.io_out, 0);
        rst = 1'b0;
        #1;
        chk("load_ready", bus.load_ready, 1);
        chk("load_cpu_rst", bus.cpu_rst, 1);

        // CPU read ignored while loading
        bus.cpu_R = 1'b0; bus.cpu_addr = 8'h00;
        #1;
        chk("load_rdata", bus.cpu_rdata, 0);
        bus.cpu_R = 1'b1;

        // first image with a valid gap between bytes 1 and 2
        bus.load_valid = 1'b1; bus.load_data = first_img[0];
        tick();
        chk("cnt_b1", bus.load_count, 1);
        bus.load_valid = 1'b0; bus.load_data = 8'hFF;
        tick();
        chk("cnt_gap", bus.load_count, 1);
        bus.load_valid = 1'b1; bus.load_data = first_img[1];
        tick();
        chk("cnt_b2", bus.load_count, 2);
        bus.load_data = first_img[2];
        tick();
        chk("cnt_b3", bus.load_count, 3);
        bus.load_data = first_img[3]; bus.load_last = 1'b1;
        #1;
        chk("last_cpu_rst_before", bus.cpu_rst, 1);
        tick();
        chk("cnt_b4", bus.load_count, 4);
        chk("run_cpu_rst", bus.cpu_rst, 0);
        chk("run_ready", bus.load_ready, 0);
        bus.load_valid = 1'b0; bus.load_last = 1'b0;

        // RUN reads, same cycle
        bus.cpu_R = 1'b0; bus.cpu_addr = 8'h02;
        #1;
        chk("rd_addr2", bus.cpu_rdata, 8'hC6);
        for (int i = 0; i < 4; i++) begin
            bus.cpu_addr = 8'(i);
            #1;
            chk($sformatf("rd_img%0d", i), bus.cpu_rdata, first_img[i]);
        end
        bus.cpu_R = 1'b1;
        #1;
        chk("rd_idle", bus.cpu_rdata, 0);

        // RUN write then read, then read-during-write returns old data
        bus.cpu_addr = 8'h80; bus.cpu_W = 1'b0; bus.cpu_wdata = 8'h5A;
        tick();
        bus.cpu_W = 1'b1; bus.cpu_R = 1'b0;
        #1;
        chk("wr_rd_80", bus.cpu_rdata, 8'h5A);
        bus.cpu_W = 1'b0; bus.cpu_wdata = 8'h77;
        #1;
        chk("rw_old", bus.cpu_rdata, 8'h5A);
        tick();
        bus.cpu_W = 1'b1;
        #1;
        chk("rw_new", bus.cpu_rdata, 8'h77);

        // I/O read
        bus.io_in = 8'hA7; bus.cpu_addr = 8'hFF;
        #1;
        chk("io_rd", bus.cpu_rdata, 8'hA7);
        bus.cpu_R = 1'b1;

        // reload with a CPU write in the same cycle
        bus.reload = 1'b1; bus.cpu_addr = 8'h81; bus.cpu_W = 1'b0; bus.cpu_wdata = 8'h99;
        #1;
        chk("reload_cpu_rst_pre", bus.cpu_rst, 0);
        tick();
        bus.reload = 1'b0; bus.cpu_W = 1'b1;
        chk("reload_cpu_rst", bus.cpu_rst, 1);
        chk("reload_ready", bus.load_ready, 1);
        chk("reload_count", bus.load_count, 0);
        chk("reload_wr81", dut.mem_q[8'h81], 8'h99);

        // 256-byte image without last -> overflow
        for (int i = 0; i < 256; i++) begin
            bus.load_valid = 1'b1; bus.load_data = 8'(i + 8'h30);
            if (i == 255) begin
                #1;
                chk("ovf_pre_cpu_rst", bus.cpu_rst, 1);
                chk("ovf_pre_count", bus.load_count, 255);
                chk("ovf_pre_flag", bus.load_ovf, 0);
            end
            tick();
        end
        chk("ovf_flag", bus.load_ovf, 1);
        chk("ovf_count", bus.load_count, 256);
        chk("ovf_cpu_rst", bus.cpu_rst, 0);
        chk("ovf_257_ready", bus.load_ready, 0);
        tick();
        chk("ovf_count_hold", bus.load_count, 256);
        bus.load_valid = 1'b0;

        bus.cpu_R = 1'b0; bus.cpu_addr = 8'h10;
        #1;
        chk("ovf_rd10", bus.cpu_rdata, 8'h40);
        bus.cpu_addr = 8'h80;
        #1;
        chk("ovf_rd80", bus.cpu_rdata, 8'hB0);
        bus.cpu_R = 1'b1;

        // I/O write does not touch RAM
        bus.cpu_addr = 8'hFF; bus.cpu_W = 1'b0; bus.cpu_wdata = 8'h3C;
        tick();
        bus.cpu_W = 1'b1;
        chk("io_out", bus.io_out, 8'h3C);
        chk("io_mem_ff", dut.mem_q[8'hFF], 8'h2F);

        // reload, one byte, then reset during the second byte
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
        chk("rl2_ovf_clr", bus.load_ovf, 0);
        chk("rl2_io_hold", bus.io_out, 8'h3C);
        bus.load_valid = 1'b1; bus.load_data = 8'hE1;
        tick();
        chk("rl2_cnt1", bus.load_count, 1);
        chk("rl2_cpu_rst1", bus.cpu_rst, 1);
        bus.load_data = 8'h55; rst = 1'b1;
        #1;
        chk("midrst_ready", bus.load_ready, 0);
        chk("midrst_cpu_rst", bus.cpu_rst, 1);
        tick();
        rst = 1'b0; bus.load_valid = 1'b0;
        #1;
        chk("midrst_count", bus.load_count, 0);
        chk("midrst_cpu_rst_after", bus.cpu_rst, 1);
        chk("midrst_io_out", bus.io_out, 0);
        chk("midrst_mem0", dut.mem_q[0], 8'hE1);
        chk("midrst_mem1", dut.mem_q[1], 8'h31);

        // restart from ptr 0 with a one-byte image
        bus.load_valid = 1'b1; bus.load_data = 8'h42; bus.load_last = 1'b1;
        tick();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
        chk("rl3_cpu_rst", bus.cpu_rst, 0);
        chk("rl3_count", bus.load_count, 1);
        bus.cpu_R = 1'b0; bus.cpu_addr = 8'h00;
        #1;
        chk("rl3_rd0", bus.cpu_rdata, 8'h42);
        bus.cpu_addr = 8'h01;
        #1;
        b = bus.cpu_rdata;
        chk("rl3_rd1", b, 8'h31);
        bus.cpu_R = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
